// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid fetcher feeding a
// one-entry valid/ready output buffer, with branch redirect and in-flight squash.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state;
  logic [31:0] fetch_pc;
  logic        kill;
  logic        grant;

  assign imem_addr_o = fetch_pc;
  // A fetch may only issue when its result has somewhere to land this cycle.
  assign imem_req_o  = (state == REQ) && (!instr_valid_o || instr_ready_i);
  assign grant       = imem_req_o && imem_gnt_i;

  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // later assignments in the block deliberately override earlier ones.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      kill          <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= NOP_INSTR;
      pc_o          <= RESET_PC;
      misalign_o    <= 1'b0;
    end else begin
      misalign_o <= 1'b0;

      if (instr_valid_o && instr_ready_i)
        instr_valid_o <= 1'b0;

      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (grant)
            state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state <= REQ;
            kill  <= 1'b0;
            // A redirect in the same cycle makes this word stale as well.
            if (!kill && !br_taken_i) begin
              instr_o       <= imem_rdata_i;
              pc_o          <= fetch_pc;
              instr_valid_o <= 1'b1;
              fetch_pc      <= fetch_pc + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Redirect overrides the normal PC advance and flushes the buffer.
      if (br_taken_i) begin
        fetch_pc      <= {br_target_i[31:2], 2'b00};
        misalign_o    <= |br_target_i[1:0];
        instr_valid_o <= 1'b0;
        case (state)
          REQ:     if (grant) kill <= 1'b1;
          WAIT:    if (!imem_rvalid_i) kill <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
